i2c_multi_sniff: RTL

I2C_MULTI_SNIFF -- requirements
Module: i2c_multi_sniff

---
 rtl/i2c_multi_sniff_pkg.sv | 28 ++
 rtl/i2c_multi_sniff_chan.sv | 133 +++++++++++++
 rtl/i2c_multi_sniff.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/i2c_multi_sniff_pkg.sv
// Shared types for the multi-channel I2C sniffer: record layout, decoder
// FSM states and the bus ACK polarity.
package i2c_multi_sniff_pkg;

    localparam int   REC_W   = 11;
    localparam logic ACK_POL = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_DATA = 2'd1,
        ST_ACK       = 2'd2
    } chan_state_e;

    typedef struct packed {
        logic       sop;
        logic       eot;
        logic [7:0] data;
        logic       ack;
    } rec_t;

    function automatic rec_t eot_record();
        rec_t r;
        r     = '0;
        r.eot = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/i2c_multi_sniff_chan.sv
// Single-bus decoder: synchronises SCL/SDA, finds START/STOP and SCL rising
// edges, and emits one registered record per byte or STOP.
module i2c_chan_decoder
    import i2c_multi_sniff_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_rec_valid,
    output rec_t o_rec
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl_cur;
    logic                   w_sda_cur;
    logic                   w_scl_rise;
    logic                   w_start;
    logic                   w_stop;
    chan_state_e            r_state;
    chan_state_e            w_state_nx;
    logic [2:0]             r_cnt;
    logic [2:0]             w_cnt_nx;
    logic [7:0]             r_shift;
    logic [7:0]             w_shift_nx;
    logic                   r_sop;
    logic                   w_sop_nx;
    logic                   w_push;
    rec_t                   w_rec;
    logic                   r_rec_valid;
    rec_t                   r_rec;

    // Synchronisers idle high so leaving reset never looks like a START.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl_cur  = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_cur  = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl_cur & ~r_scl_prev;
    assign w_start    = r_scl_prev & w_scl_cur & r_sda_prev & ~w_sda_cur;
    assign w_stop     = r_scl_prev & w_scl_cur & ~r_sda_prev & w_sda_cur;

    // Decoder state, bit shifter and record register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_shift     <= 8'd0;
            r_sop       <= 1'b0;
            r_rec_valid <= 1'b0;
            r_rec       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_shift     <= w_shift_nx;
            r_sop       <= w_sop_nx;
            r_rec_valid <= w_push;
            r_rec       <= w_rec;
        end
    end

    // STOP outranks START, which outranks SCL sampling; IDLE ignores SCL.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shift_nx = r_shift;
        w_sop_nx   = r_sop;
        w_push     = 1'b0;
        w_rec      = '0;
        if (w_stop) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = 3'd0;
            w_shift_nx = 8'd0;
            if (r_state != ST_IDLE) begin
                w_push = 1'b1;
                w_rec  = eot_record();
            end else begin
                w_push = 1'b0;
            end
        end else if (w_start) begin
            w_state_nx = ST_ADDR_DATA;
            w_cnt_nx   = 3'd0;
            w_shift_nx = 8'd0;
            w_sop_nx   = 1'b1;
        end else if (w_scl_rise) begin
            case (r_state)
                ST_ADDR_DATA: begin
                    w_shift_nx = {r_shift[6:0], w_sda_cur};
                    w_cnt_nx   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_state_nx = ST_ACK;
                    end else begin
                        w_state_nx = ST_ADDR_DATA;
                    end
                end
                ST_ACK: begin
                    w_push     = 1'b1;
                    w_rec.sop  = r_sop;
                    w_rec.data = r_shift;
                    w_rec.ack  = w_sda_cur;
                    w_sop_nx   = 1'b0;
                    w_cnt_nx   = 3'd0;
                    w_state_nx = ST_ADDR_DATA;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end else begin
            w_push = 1'b0;
        end
    end

    assign o_rec_valid = r_rec_valid;
    assign o_rec       = r_rec;

endmodule

// File: rtl/i2c_multi_sniff.sv
// Multi-bus I2C sniffer top: one decoder and record FIFO per channel, merged
// by a round-robin arbiter into a registered valid/ready output.
module i2c_multi_sniff
    import i2c_multi_sniff_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] scl,
    input  logic [CHANNELS-1:0] sda,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8:0]          out_data,
    output logic [CW-1:0]       out_chan,
    output logic                out_sop,
    output logic                out_eot,
    output logic [CHANNELS-1:0] overflow
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]  LAST_CH = CW'(CHANNELS-1);

    logic [CHANNELS-1:0] w_dec_valid;
    rec_t                w_dec_rec [CHANNELS];
    logic [REC_W-1:0]    r_mem     [CHANNELS][FIFO_DEPTH];
    logic [AW:0]         r_wptr    [CHANNELS];
    logic [AW:0]         r_rptr    [CHANNELS];
    logic [CHANNELS-1:0] r_overflow;
    logic [CHANNELS-1:0] w_pop;
    logic [CHANNELS-1:0] w_wr;
    logic [CHANNELS-1:0] w_drop;
    logic [CHANNELS-1:0] w_avail;
    rec_t                w_head    [CHANNELS];
    logic                r_out_valid;
    rec_t                r_out_rec;
    logic [CW-1:0]       r_out_chan;
    logic [CW-1:0]       r_rr_ptr;
    logic                w_hs;
    logic [CW-1:0]       w_ptr_eff;
    logic [CW-1:0]       w_cand;
    logic [CW-1:0]       w_grant;
    logic                w_found;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        i2c_chan_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_dec (
            .i_clk       (clk),
            .i_reset     (reset),
            .i_scl       (scl[g]),
            .i_sda       (sda[g]),
            .o_rec_valid (w_dec_valid[g]),
            .o_rec       (w_dec_rec[g])
        );
    end

    assign w_hs      = r_out_valid & out_ready;
    assign w_ptr_eff = w_hs ? ((r_out_chan == LAST_CH) ? CW'(0) : r_out_chan + CW'(1)) : r_rr_ptr;

    // The presented record stays in its FIFO until accepted, so look past it
    // when it is being popped to keep full throughput.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_pop[c]   = w_hs && (r_out_chan == CW'(c));
            w_wr[c]    = w_dec_valid[c] && (((r_wptr[c] - r_rptr[c]) != DEPTH_L) || w_pop[c]);
            w_drop[c]  = w_dec_valid[c] && ((r_wptr[c] - r_rptr[c]) == DEPTH_L) && !w_pop[c];
            w_avail[c] = (r_wptr[c] - r_rptr[c]) != (AW+1)'(w_pop[c]);
            w_head[c]  = r_mem[c][r_rptr[c][AW-1:0] + AW'(w_pop[c])];
        end
    end

    // Round-robin search starting at the (possibly just advanced) pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = w_ptr_eff;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && w_avail[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end else begin
                w_found = w_found;
            end
            w_cand = (w_cand == LAST_CH) ? CW'(0) : w_cand + CW'(1);
        end
    end

    // FIFO pointers and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wr[c]) r_wptr[c] <= r_wptr[c] + (AW+1)'(1);
                if (w_pop[c]) r_rptr[c] <= r_rptr[c] + (AW+1)'(1);
            end
            r_overflow <= r_overflow | w_drop;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_wr[c]) r_mem[c][r_wptr[c][AW-1:0]] <= w_dec_rec[c];
        end
    end

    // Output register: reload when idle or on a handshake, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_rec   <= '0;
            r_out_chan  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_hs) r_rr_ptr <= w_ptr_eff;
            if (w_hs || !r_out_valid) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_rec  <= w_head[w_grant];
                    r_out_chan <= w_grant;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = {r_out_rec.data, r_out_rec.ack};
    assign out_chan  = r_out_chan;
    assign out_sop   = r_out_rec.sop;
    assign out_eot   = r_out_rec.eot;
    assign overflow  = r_overflow;

endmodule
